// File: rtl/oc_pkg.sv
// -----------------------------------------------------------------------------
// oc_pkg
// Shared types and defaults for the phase over-current detector.
//   oc_state_t : detector operating state (INIT fill, RUN compare, FAULT).
//   DEF_*      : default sample width, window, thresholds, blanking, timeout.
//   sum_width  : width of the running sum for a given sample width/window.
// -----------------------------------------------------------------------------
package oc_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } oc_state_t;

  localparam int DEF_SAMPLE_W     = 12;
  localparam int DEF_AVG_LOG2     = 3;
  localparam int DEF_TRIP_TH      = 2000;
  localparam int DEF_CLEAR_TH     = 1500;
  localparam int DEF_BLANK_CYCLES = 50;
  localparam int DEF_ADC_TIMEOUT  = 1000;

  // Summing 2^avg_log2 unsigned samples needs avg_log2 extra bits, so the
  // running sum can never overflow.
  function automatic int sum_width(input int sample_w, input int avg_log2);
    return sample_w + avg_log2;
  endfunction

endpackage

// File: rtl/oc_avg_filter.sv
// -----------------------------------------------------------------------------
// oc_avg_filter
// Moving-average filter over the last 2^AVG_LOG2 accepted samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : synchronous clear of buffer, pointer, sum and average
//   i_load     : write i_sample into the window this cycle
//   i_sample   : unsigned sample
//   o_avg      : registered window average (sum >> AVG_LOG2)
// -----------------------------------------------------------------------------
module oc_avg_filter
  import oc_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_load,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic [SAMPLE_W-1:0] o_avg
);

  localparam int SUM_W = sum_width(SAMPLE_W, AVG_LOG2);
  localparam int DEPTH = 1 << AVG_LOG2;

  logic [SAMPLE_W-1:0] r_buf [DEPTH];
  logic [AVG_LOG2-1:0] r_ptr;
  logic [SUM_W-1:0]    r_sum;
  logic [SAMPLE_W-1:0] r_avg;
  logic [SUM_W-1:0]    w_sum_next;

  // The slot at r_ptr holds the oldest sample; the sum always contains it,
  // so the subtraction cannot underflow. Zero-extension only, never sign.
  assign w_sum_next = r_sum - SUM_W'(r_buf[r_ptr]) + SUM_W'(i_sample);

  // NOTE: the buffer is reset along with the sum because the running sum is
  // only correct if every slot it subtracts really holds what was added.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_ptr <= '0;
      r_sum <= '0;
      r_avg <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_ptr <= '0;
      r_sum <= '0;
      r_avg <= '0;
    end else if (i_load) begin
      r_buf[r_ptr] <= i_sample;
      r_ptr        <= r_ptr + AVG_LOG2'(1);
      r_sum        <= w_sum_next;
      r_avg        <= w_sum_next[SUM_W-1:AVG_LOG2];
    end
  end

  assign o_avg = r_avg;

endmodule

// File: rtl/overcurrent_detect.sv
// -----------------------------------------------------------------------------
// overcurrent_detect
// Filters phase-current ADC samples and produces the over-current level for
// the I2t integrator, with PWM-edge blanking and an ADC-silence fail-safe.
//   clk, rst_n   : clock, asynchronous active-low reset
//   pwm_edge     : one-cycle pulse at each PWM switching edge
//   adc_valid    : adc_data valid
//   adc_data     : unsigned current sample
//   adc_ready    : block can accept a sample
//   over_current : filtered over-current level (hysteresis), to I2t
//   i_avg        : current moving average
//   adc_fault    : ADC sample timeout active
// -----------------------------------------------------------------------------
module overcurrent_detect
  import oc_pkg::*;
#(
  parameter int SAMPLE_W     = DEF_SAMPLE_W,
  parameter int AVG_LOG2     = DEF_AVG_LOG2,
  parameter int TRIP_TH      = DEF_TRIP_TH,
  parameter int CLEAR_TH     = DEF_CLEAR_TH,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int ADC_TIMEOUT  = DEF_ADC_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_edge,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                adc_ready,
  output logic                over_current,
  output logic [SAMPLE_W-1:0] i_avg,
  output logic                adc_fault
);

  if (CLEAR_TH >= TRIP_TH) begin : g_bad_thresholds
    $error("overcurrent_detect: CLEAR_TH must be below TRIP_TH");
  end

  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int TO_W    = $clog2(ADC_TIMEOUT + 1);
  localparam int FILL_W  = AVG_LOG2 + 1;

  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);
  localparam logic [TO_W-1:0]    TO_LIMIT   = TO_W'(ADC_TIMEOUT);
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'((1 << AVG_LOG2) - 1);
  localparam logic [31:0]        TRIP_V     = 32'(TRIP_TH);
  localparam logic [31:0]        CLEAR_V    = 32'(CLEAR_TH);

  logic               r_adc_ready;
  logic [BLANK_W-1:0] r_blank_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  oc_state_t          r_state;
  logic [FILL_W-1:0]  r_fill_cnt;
  logic               r_over_current;
  logic               r_adc_fault;

  logic                w_accept;
  logic                w_blanked;
  logic                w_load;
  logic                w_timeout;
  logic                w_enter_fault;
  logic [SAMPLE_W-1:0] w_avg;
  logic [31:0]         w_avg_ext;

  assign w_accept  = adc_valid && r_adc_ready;
  assign w_blanked = (r_blank_cnt != '0);
  // Blanked samples still complete the handshake but never reach the filter.
  assign w_load    = w_accept && !w_blanked;
  // A sample arriving in the cycle the limit is reached pre-empts the fault.
  assign w_timeout     = (r_to_cnt == TO_LIMIT) && !w_accept;
  assign w_enter_fault = w_timeout && (r_state != FAULT);
  assign w_avg_ext     = 32'(w_avg);

  oc_avg_filter #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_enter_fault),
    .i_load   (w_load),
    .i_sample (adc_data),
    .o_avg    (w_avg)
  );

  // Handshake, blanking and timeout bookkeeping, identical in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adc_ready <= 1'b1;
      r_blank_cnt <= '0;
      r_to_cnt    <= '0;
    end else begin
      // One dead cycle after each accept while the sum updates.
      r_adc_ready <= !w_accept;

      if (pwm_edge) begin
        r_blank_cnt <= BLANK_LOAD;
      end else if (w_blanked) begin
        r_blank_cnt <= r_blank_cnt - BLANK_W'(1);
      end

      // Saturates at the limit so a long silence cannot wrap back to safe.
      if (w_accept) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_LIMIT) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // Operating state with registered outputs and the hysteresis comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= INIT;
      r_fill_cnt     <= '0;
      r_over_current <= 1'b0;
      r_adc_fault    <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_over_current <= 1'b0;
          if (w_enter_fault) begin
            r_state        <= FAULT;
            r_fill_cnt     <= '0;
            r_over_current <= 1'b1;
            r_adc_fault    <= 1'b1;
          end else if (w_load) begin
            r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            // The comparator first runs next cycle, on the average that
            // already contains this last fill sample.
            if (r_fill_cnt == FILL_LAST) r_state <= RUN;
          end
        end
        RUN: begin
          if (w_enter_fault) begin
            r_state        <= FAULT;
            r_fill_cnt     <= '0;
            r_over_current <= 1'b1;
            r_adc_fault    <= 1'b1;
          end else if (w_avg_ext >= TRIP_V) begin
            r_over_current <= 1'b1;
          end else if (w_avg_ext <= CLEAR_V) begin
            r_over_current <= 1'b0;
          end
        end
        FAULT: begin
          // Any sample proves the ADC is alive again; only an unblanked one
          // is also the first fill sample of the fresh window.
          if (w_accept) begin
            r_state        <= INIT;
            r_over_current <= 1'b0;
            r_adc_fault    <= 1'b0;
            r_fill_cnt     <= w_load ? FILL_W'(1) : '0;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign adc_ready    = r_adc_ready;
  assign over_current = r_over_current;
  assign i_avg        = w_avg;
  assign adc_fault    = r_adc_fault;

endmodule

// File: tb/tb_overcurrent_detect.sv
// -----------------------------------------------------------------------------
// tb_overcurrent_detect
// Scoreboard bench for overcurrent_detect: the driver pushes expected
// average / over-current / fault / ready values tagged with the cycle they
// must appear in; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_overcurrent_detect;
  import oc_pkg::*;

  localparam int SW      = 12;
  localparam int WIN     = 8;
  localparam int TRIP    = 2000;
  localparam int CLEAR   = 1500;
  localparam int BLANK   = 50;
  localparam int TIMEOUT = 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pwm_edge;
  logic          adc_valid;
  logic [SW-1:0] adc_data;
  logic          adc_ready;
  logic          over_current;
  logic [SW-1:0] i_avg;
  logic          adc_fault;

  overcurrent_detect #(
    .SAMPLE_W     (SW),
    .AVG_LOG2     (3),
    .TRIP_TH      (TRIP),
    .CLEAR_TH     (CLEAR),
    .BLANK_CYCLES (BLANK),
    .ADC_TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_edge     (pwm_edge),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .adc_ready    (adc_ready),
    .over_current (over_current),
    .i_avg        (i_avg),
    .adc_fault    (adc_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  localparam int SEL_AVG = 0, SEL_OC = 1, SEL_FLT = 2, SEL_RDY = 3;

  typedef struct {
    int    due;
    int    sel;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];

  task automatic expect_at(input int due, input int sel, input int val, input string tag);
    exp_t e;
    e.due = due;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_AVG: return 32'(i_avg);
      SEL_OC:  return 32'(over_current);
      SEL_FLT: return 32'(adc_fault);
      default: return 32'(adc_ready);
    endcase
  endfunction

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        check(sb[i].tag, observe(sb[i].sel), 32'(sb[i].val));
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  // ---------------- reference model ----------------
  int        m_buf [WIN];
  int        m_sum, m_ptr, m_fill;
  oc_state_t m_state;
  bit        m_oc, m_fault;
  int        last_acc;

  task automatic model_clear();
    for (int i = 0; i < WIN; i++) m_buf[i] = 0;
    m_sum  = 0;
    m_ptr  = 0;
    m_fill = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_state = INIT;
    m_oc    = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_fault();
    model_clear();
    m_state = FAULT;
    m_oc    = 1'b1;
    m_fault = 1'b1;
  endtask

  // Returns what the DUT must show the cycle after the accept (avg, oc,
  // fault) and the over-current level one cycle later.
  task automatic model_accept(input int d, input bit blanked,
                              output int e_avg, output bit e_oc0,
                              output bit e_oc1, output bit e_flt);
    if (m_state == FAULT) begin
      m_state = INIT;
      m_oc    = 1'b0;
      m_fault = 1'b0;
    end
    e_oc0 = m_oc;
    e_flt = m_fault;
    if (!blanked) begin
      m_sum        = m_sum - m_buf[m_ptr] + d;
      m_buf[m_ptr] = d;
      m_ptr        = (m_ptr + 1) % WIN;
      if (m_state == INIT) begin
        m_fill++;
        if (m_fill == WIN) m_state = RUN;
      end
    end
    e_avg = m_sum / WIN;
    if (m_state == RUN) begin
      if (e_avg >= TRIP) m_oc = 1'b1;
      else if (e_avg <= CLEAR) m_oc = 1'b0;
    end
    e_oc1 = m_oc;
  endtask

  // ---------------- driver ----------------
  task automatic send(input int d, input bit blanked, input string tag);
    int budget;
    int e_avg;
    bit e_oc0, e_oc1, e_flt;
    adc_data  = SW'(d);
    adc_valid = 1'b1;
    budget    = 0;
    while (adc_ready !== 1'b1 && budget < 8) begin
      @(posedge clk); #1;
      budget++;
    end
    check($sformatf("%s_rdy_wait", tag), 32'(adc_ready), 32'd1);
    @(posedge clk); #1;
    adc_valid = 1'b0;
    last_acc  = cyc;
    model_accept(d, blanked, e_avg, e_oc0, e_oc1, e_flt);
    expect_at(cyc,     SEL_AVG, e_avg, $sformatf("%s_avg", tag));
    expect_at(cyc,     SEL_OC,  e_oc0, $sformatf("%s_oc_t1", tag));
    expect_at(cyc,     SEL_FLT, e_flt, $sformatf("%s_flt", tag));
    expect_at(cyc,     SEL_RDY, 0,     $sformatf("%s_rdy_lo", tag));
    expect_at(cyc + 1, SEL_OC,  e_oc1, $sformatf("%s_oc_t2", tag));
    expect_at(cyc + 1, SEL_RDY, 1,     $sformatf("%s_rdy_hi", tag));
    @(posedge clk); #1;
  endtask

  task automatic pulse_pwm();
    pwm_edge = 1'b1;
    @(posedge clk); #1;
    pwm_edge = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_rdy", tag),   32'(adc_ready),    32'd1);
    check($sformatf("%s_oc", tag),    32'(over_current), 32'd0);
    check($sformatf("%s_avg", tag),   32'(i_avg),        32'd0);
    check($sformatf("%s_flt", tag),   32'(adc_fault),    32'd0);
    check($sformatf("%s_state", tag), 32'(dut.r_state),  32'(INIT));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    pwm_edge  = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    // Fill the window: INIT for 8 samples, then RUN at average 1000.
    for (int i = 0; i < WIN; i++) send(1000, 1'b0, $sformatf("fill%0d", i));
    check("fill_state", 32'(dut.r_state), 32'(m_state));

    // 4th sample of 3000 brings the average to exactly 2000.
    for (int i = 0; i < 4; i++) send(3000, 1'b0, $sformatf("trip%0d", i));

    // Hysteresis: 1600 holds the trip, 1000 clears once avg <= 1500.
    for (int i = 0; i < WIN; i++) send(1600, 1'b0, $sformatf("hold%0d", i));
    for (int i = 0; i < WIN; i++) send(1000, 1'b0, $sformatf("clr%0d", i));

    // Blanking: accept at the 50th edge after pwm_edge is discarded, at the
    // 51st it is averaged in.
    pulse_pwm();
    repeat (BLANK - 1) @(posedge clk);
    #1;
    send(4095, 1'b1, "blank50");
    pulse_pwm();
    repeat (BLANK) @(posedge clk);
    #1;
    send(4095, 1'b0, "blank51");

    // Timeout: 1000 silent edges are tolerated, the next one faults.
    while (cyc < last_acc + TIMEOUT) begin
      @(posedge clk); #1;
    end
    check("to_pre_flt", 32'(adc_fault),    32'd0);
    check("to_pre_oc",  32'(over_current), 32'd0);
    @(posedge clk); #1;
    model_fault();
    check("to_flt",   32'(adc_fault),    32'(m_fault));
    check("to_oc",    32'(over_current), 32'(m_oc));
    check("to_avg",   32'(i_avg),        32'd0);
    check("to_state", 32'(dut.r_state),  32'(m_state));

    // Recovery: fault clears on the first accept, RUN after 8 samples.
    for (int i = 0; i < WIN; i++) send(1000, 1'b0, $sformatf("rec%0d", i));
    check("rec_state", 32'(dut.r_state), 32'(m_state));

    // Accept in the very cycle the limit is reached: no fault.
    while (cyc < last_acc + TIMEOUT) begin
      @(posedge clk); #1;
    end
    send(1000, 1'b0, "to_edge");
    check("to_edge_state", 32'(dut.r_state), 32'(m_state));

    // Trip again, then assert reset mid-handshake.
    for (int i = 0; i < 4; i++) send(3000, 1'b0, $sformatf("trip2_%0d", i));
    check("pre_rst_oc", 32'(over_current), 32'(m_oc));
    adc_data  = SW'(3000);
    adc_valid = 1'b1;
    @(posedge clk); #1;
    check("mid_hs_rdy", 32'(adc_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    check("async_rst_fill", 32'(dut.r_fill_cnt), 32'd0);
    adc_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
